// File: rtl/fifo_pack_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pack_pkg
//   Shared definitions for the FIFO word packer: default geometry, derived
//   widths, flush FSM state encoding and the keep-mask helper.
// ---------------------------------------------------------------------------
package fifo_pack_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int PACK_RATIO_DEF  = 4;
  localparam int COUNT_WIDTH_DEF = 33;

  // Lane index must represent 0..PACK_RATIO inclusive, hence the extra bit.
  localparam int LANE_IDX_W = $clog2(PACK_RATIO_DEF) + 1;
  localparam int OUT_WIDTH  = DATA_WIDTH_DEF * PACK_RATIO_DEF;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_DRAIN,
    FL_EMIT
  } fl_state_e;

  // One bit of the partial-word keep mask ((1 << n_filled) - 1), evaluated
  // per lane so the caller never has to carry a fixed-width mask around.
  function automatic logic keep_bit(input int unsigned lane, input int unsigned n_filled);
    return lane < n_filled;
  endfunction

endpackage

// File: rtl/fifo_pack_lane_acc.sv
// ---------------------------------------------------------------------------
// fifo_pack_lane_acc
//   One lane of the packing accumulator: decodes its own write enable from
//   the shared lane index and holds the captured byte.
// Ports
//   clk, rst_n  clock, async active-low reset
//   i_wr        a FIFO byte is landing this cycle
//   i_lane      lane the landing byte is destined for
//   i_data      FIFO data_out
//   o_data      stored lane byte
// ---------------------------------------------------------------------------
module fifo_pack_lane_acc
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 3,
  parameter int LANE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [IDX_W-1:0]      i_lane,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  w_we;
  logic [DATA_WIDTH-1:0] r_data;

  assign w_we = i_wr && (i_lane == IDX_W'(LANE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_data <= '0;
    else if (w_we) r_data <= i_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/fifo_word_packer.sv
// ---------------------------------------------------------------------------
// fifo_word_packer
//   Pops bytes from a sync FIFO and packs PACK_RATIO of them (lane 0 first)
//   into one word on a valid/ready stream. flush emits a partial word with a
//   keep mask and m_last set, then pulses flush_done.
// Ports
//   clk, rst_n   clock, async active-low reset
//   fifo_count   FIFO occupancy (only !=0 matters)
//   fifo_data    FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en   pop strobe (combinational)
//   flush        1-cycle request to emit the partial word
//   m_valid/m_ready/m_data/m_keep/m_last   output stream
//   flush_done   1-cycle pulse when the flush sequence completes
//   busy         any work in flight
// ---------------------------------------------------------------------------
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PACK_RATIO  = 4,
  parameter int COUNT_WIDTH = 33
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [COUNT_WIDTH-1:0]           fifo_count,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_last,
  output logic                             flush_done,
  output logic                             busy
);

  localparam int               IDX_W = $clog2(PACK_RATIO) + 1;
  localparam logic [IDX_W-1:0] FULL  = IDX_W'(PACK_RATIO);

  fl_state_e                             r_state, w_state_nxt;
  logic [IDX_W-1:0]                      r_idx, w_sum, w_wr_lane;
  logic                                  r_pend, r_valid, r_last, r_done;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] w_acc, w_acc_msk, r_data;
  logic [PACK_RATIO-1:0]                 r_keep, w_fl_keep;
  logic                                  w_flush_pend, w_can_load, w_xfer;
  logic                                  w_fl_load, w_done_nxt;

  // ---- pop control -------------------------------------------------------
  assign w_flush_pend = (r_state != FL_IDLE);
  assign w_can_load   = !r_valid || m_ready;
  assign w_xfer       = (r_idx == FULL) && w_can_load;
  assign w_sum        = r_idx + IDX_W'(r_pend);

  // Counting the in-flight byte (r_pend) guarantees a slot for it; the xfer
  // term lets the pop overlap the cycle the full word leaves. rst_n gates the
  // strobe so nothing is popped while the packer is held in reset.
  assign fifo_rd_en = rst_n && (fifo_count != '0) && !w_flush_pend &&
                      ((w_sum < FULL) || w_xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_pend <= fifo_rd_en;
      if (w_xfer)         r_idx <= IDX_W'(r_pend);   // landing byte restarts at lane 0
      else if (w_fl_load) r_idx <= '0;
      else if (r_pend)    r_idx <= r_idx + IDX_W'(1);
    end
  end

  // ---- accumulator lanes ---------------------------------------------------
  assign w_wr_lane = w_xfer ? '0 : r_idx;

  for (genvar l = 0; l < PACK_RATIO; l++) begin : g_lane
    fifo_pack_lane_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W),
      .LANE       (l)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wr   (r_pend),
      .i_lane (w_wr_lane),
      .i_data (fifo_data),
      .o_data (w_acc[l])
    );
    // Lanes above idx hold stale bytes from an earlier word; zero them.
    assign w_fl_keep[l] = keep_bit(l, 32'(r_idx));
    assign w_acc_msk[l] = w_fl_keep[l] ? w_acc[l] : '0;
  end

  // ---- flush FSM -----------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FL_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fl_load   = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      FL_IDLE:  if (flush) w_state_nxt = FL_DRAIN;
      // Let the in-flight byte land and any full word go out first.
      FL_DRAIN: if (!r_pend && (r_idx != FULL)) w_state_nxt = FL_EMIT;
      // Partial word loads (idx returns to 0), then done on the following cycle.
      FL_EMIT: begin
        if (r_idx != '0) begin
          w_fl_load = w_can_load;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = FL_IDLE;
        end
      end
      default: w_state_nxt = FL_IDLE;
    endcase
  end

  // ---- output register -----------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_xfer) begin
        r_data  <= w_acc;
        r_keep  <= '1;
        r_last  <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_fl_load) begin
        r_data  <= w_acc_msk;
        r_keep  <= w_fl_keep;
        r_last  <= 1'b1;
        r_valid <= 1'b1;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign m_keep     = r_keep;
  assign m_last     = r_last;
  assign flush_done = r_done;
  assign busy       = r_pend || (r_idx != '0) || r_valid || w_flush_pend;

endmodule

// File: tb/tb_fifo_word_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_word_packer
//   Directed bench for fifo_word_packer with a behavioural FIFO model
//   (registered data_out) and a byte scoreboard for the random-traffic phase.
// ---------------------------------------------------------------------------
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int CW = 33;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          flush   = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;
  logic          m_last, flush_done, busy;

  int n_checks = 0;
  int n_err    = 0;

  // FIFO model
  logic [7:0] mem [0:2047];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       gate   = 1'b1;

  // scoreboard
  logic       sb_en  = 1'b0;
  int         sb_idx = 0;
  logic [7:0] exp_b [0:1023];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_count (fifo_count),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .flush_done (flush_done),
    .busy       (busy)
  );

  assign fifo_count = gate ? CW'(wr_ptr - rd_ptr) : '0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[10:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[10:0]] = b;
    wr_ptr++;
  endtask

  // Continuous monitors: no pop from an empty FIFO; accepted words in order.
  always @(negedge clk) begin
    if (fifo_count == '0) begin
      n_checks++;
      assert (fifo_rd_en === 1'b0) else begin
        n_err++;
        $error("FAIL pop_on_empty: observed %0b expected 0", fifo_rd_en);
      end
    end
    if (sb_en && m_valid && m_ready && sb_idx < 1000) begin
      sb_exp = {exp_b[sb_idx+3], exp_b[sb_idx+2], exp_b[sb_idx+1], exp_b[sb_idx]};
      n_checks++;
      assert ({m_last, m_keep, m_data} === {1'b0, 4'hF, sb_exp}) else begin
        n_err++;
        $error("FAIL sb_word%0d: observed %0h/%0h/%0h expected 0/f/%0h",
               sb_idx / 4, m_last, m_keep, m_data, sb_exp);
      end
      sb_idx += 4;
    end
  end

  initial begin
    int          first_v, rd_mask, nv, nd, vcyc, dcyc;
    logic [31:0] d_cap;
    logic [3:0]  k_cap;
    logic        l_cap;

    // ---- reset state (FIFO preloaded while held in reset) ----
    repeat (3) nxt();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    mid();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);

    // ---- 1: four bytes, m_ready=1; pops in cycles 0..3, xfer in cycle 5,
    //      m_valid visible after that cycle's closing edge (sample cycle 6)
    nxt();
    m_ready = 1'b1;
    rst_n   = 1'b1;
    first_v = -1;
    rd_mask = 0;
    d_cap = '0; k_cap = '0; l_cap = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mid();
      if (fifo_rd_en) rd_mask |= (1 << c);
      if (m_valid && first_v < 0) begin
        first_v = c; d_cap = m_data; k_cap = m_keep; l_cap = m_last;
      end
      nxt();
    end
    chk("t1_rd_cycles", rd_mask, 32'h0000_000F);
    chk("t1_valid_cycle", first_v, 6);
    chk("t1_data", d_cap, 32'h4433_2211);
    chk("t1_keep", k_cap, 4'hF);
    chk("t1_last", l_cap, 0);
    mid();
    chk("t1_valid_dropped", m_valid, 0);
    chk("t1_idle", busy, 0);
    nxt();

    // ---- 2: eight bytes with m_ready=0: first word held, pops stop ----
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      mid();
      if (fifo_rd_en) nd++;
      if (c == 6)  chk("t2_hold_early", m_data, 32'h0403_0201);
      if (c == 13) chk("t2_hold_late", {m_valid, m_data}, {1'b1, 32'h0403_0201});
      if (c == 13) chk("t2_stalled_rd", fifo_rd_en, 0);
      nxt();
    end
    chk("t2_pops", nd, 8);
    m_ready = 1'b1;
    mid();
    chk("t2_first_at_accept", m_data, 32'h0403_0201);
    nxt();
    mid();
    chk("t2_second_word", {m_valid, m_keep, m_data}, {1'b1, 4'hF, 32'h0807_0605});
    nxt();
    mid();
    chk("t2_drained", m_valid, 0);
    nxt();

    // ---- 3: three bytes then flush -> partial word, then flush_done ----
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (6) nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    nv = 0; nd = 0; vcyc = -1; dcyc = -1;
    for (int c = 0; c < 10; c++) begin
      mid();
      if (m_valid) begin
        nv++; if (vcyc < 0) vcyc = c;
        d_cap = m_data; k_cap = m_keep; l_cap = m_last;
      end
      if (flush_done) begin nd++; dcyc = c; end
      nxt();
    end
    chk("t3_words", nv, 1);
    chk("t3_data", d_cap, 32'h00CC_BBAA);
    chk("t3_keep", k_cap, 4'h7);
    chk("t3_last", l_cap, 1);
    chk("t3_done_pulses", nd, 1);
    chk("t3_done_after_word", dcyc > vcyc, 1);

    // ---- 3b: flush in the same cycle as a pop: byte joins the flush word ----
    push(8'h5A);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    nv = 0; nd = 0;
    for (int c = 0; c < 10; c++) begin
      mid();
      if (m_valid) begin nv++; d_cap = m_data; k_cap = m_keep; l_cap = m_last; end
      if (flush_done) nd++;
      nxt();
    end
    chk("t3b_words", nv, 1);
    chk("t3b_word", {l_cap, k_cap, d_cap}, {1'b1, 4'h1, 32'h0000_005A});
    chk("t3b_done_pulses", nd, 1);

    // ---- 4: flush with nothing buffered and an empty FIFO ----
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    nv = 0; nd = 0; dcyc = -1;
    for (int c = 0; c < 6; c++) begin
      mid();
      if (m_valid) nv++;
      if (flush_done) begin nd++; dcyc = c; end
      nxt();
    end
    chk("t4_no_word", nv, 0);
    chk("t4_done_pulses", nd, 1);
    chk("t4_done_prompt", (dcyc >= 0) && (dcyc < 3), 1);

    // ---- 5: 1000 random bytes, count gated on/off, random m_ready ----
    for (int i = 0; i < 1000; i++) begin
      exp_b[i] = 8'($urandom);
      push(exp_b[i]);
    end
    sb_en = 1'b1;
    for (int c = 0; c < 20000 && sb_idx < 1000; c++) begin
      gate    = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      nxt();
    end
    gate    = 1'b1;
    m_ready = 1'b1;
    nxt();
    sb_en = 1'b0;
    chk("t5_bytes_seen", sb_idx, 1000);
    chk("t5_fifo_drained", wr_ptr - rd_ptr, 0);

    // ---- 6: async reset with a word held and idx=2 ----
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
    repeat (14) nxt();
    mid();
    chk("t6_pre_word", {m_valid, m_data}, {1'b1, 32'h6463_6261});
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs", {m_valid, m_keep, m_last, flush_done, busy, fifo_rd_en}, 0);
    chk("t6_rst_data", m_data, 0);
    nxt();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    nv = 0; d_cap = '0; k_cap = '0;
    for (int c = 0; c < 10; c++) begin
      mid();
      if (m_valid) begin nv++; d_cap = m_data; k_cap = m_keep; end
      nxt();
    end
    chk("t6_words", nv, 1);
    chk("t6_lane0_restart", {k_cap, d_cap}, {4'hF, 32'h8483_8281});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
